// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared opcodes, fetch FSM encodings and defaults for IF stage.
//  Revision    : 1.0
// ============================================================================
package fetch_stage_pkg;

    localparam logic [2:0]  NPC_DEFAULT = 3'd0;
    localparam logic [2:0]  NPC_B       = 3'd1;
    localparam logic [2:0]  NPC_J       = 3'd2;
    localparam logic [2:0]  NPC_JR      = 3'd3;

    localparam int          FETCH_STATE_W = 1;
    localparam logic [FETCH_STATE_W-1:0] FETCH_RUN  = 1'b0;
    localparam logic [FETCH_STATE_W-1:0] FETCH_PEND = 1'b1;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic is_redirect(input logic [2:0] op, input logic cmp_zero);
        return (op == NPC_J) || (op == NPC_JR) || ((op == NPC_B) && cmp_zero);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Control, instruction-memory and F/D signals of the IF stage.
//  Revision    : 1.0
// ============================================================================
interface fetch_stage_if;

    logic        stall_D;
    logic [2:0]  npc_op;
    logic        cmp_zero;
    logic [31:0] npc;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc_F;
    logic [31:0] pc_D;
    logic [31:0] instr_D;
    logic        valid_D;
    logic [31:0] bubble_cnt;

    // Pipeline control and memory side
    modport master (
        output stall_D, npc_op, cmp_zero, npc, imem_ready, imem_rdata,
        input  imem_addr, pc_F, pc_D, instr_D, valid_D, bubble_cnt
    );

    // Fetch stage itself
    modport slave (
        input  stall_D, npc_op, cmp_zero, npc, imem_ready, imem_rdata,
        output imem_addr, pc_F, pc_D, instr_D, valid_D, bubble_cnt
    );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_fd_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fd_reg
//  Description : F/D pipeline register with stall hold and bubble injection.
//  Revision    : 1.0
// ============================================================================
module fd_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        stall_i,
    input  wire logic        bubble_i,
    input  wire logic [31:0] pc_i,
    input  wire logic [31:0] instr_i,
    output logic      [31:0] pc_o,
    output logic      [31:0] instr_o,
    output logic             valid_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // A bubble still carries the PC so D can attribute the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            pc_q    <= pc_i;
            instr_q <= bubble_i ? NOP_INSTR : instr_i;
            valid_q <= !bubble_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS IF stage: PC, delay-slot aware redirect FSM, F/D register.
//  Revision    : 1.0
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fetch_stage_if.slave bus
);

    logic [FETCH_STATE_W-1:0] state_q;
    logic [FETCH_STATE_W-1:0] state_d;
    logic [31:0]              pc_q;
    logic [31:0]              pc_d;
    logic [31:0]              tgt_q;
    logic [31:0]              tgt_d;
    logic [31:0]              bubble_cnt_q;
    logic [31:0]              bubble_cnt_d;
    logic                     redirect;
    logic                     fd_bubble;

    assign redirect = is_redirect(bus.npc_op, bus.cmp_zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_RUN;
        end else if (!bus.stall_D) begin
            state_q <= state_d;
        end
    end

    // A redirect seen while IM is waiting must wait for the delay slot fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_RUN:  if (!bus.imem_ready && redirect) state_d = FETCH_PEND;
            FETCH_PEND: if (bus.imem_ready)              state_d = FETCH_RUN;
            default:    state_d = FETCH_RUN;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        bubble_cnt_d = bubble_cnt_q;
        fd_bubble    = !bus.imem_ready;
        if (!bus.imem_ready) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
            if (state_q == FETCH_RUN && redirect) begin
                tgt_d = bus.npc;
            end
        end else if (state_q == FETCH_PEND) begin
            pc_d = tgt_q;
        end else begin
            pc_d = redirect ? bus.npc : pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= PC_RESET;
            tgt_q        <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else if (!bus.stall_D) begin
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    fd_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk      (clk),
        .reset    (reset),
        .stall_i  (bus.stall_D),
        .bubble_i (fd_bubble),
        .pc_i     (pc_q),
        .instr_i  (bus.imem_rdata),
        .pc_o     (bus.pc_D),
        .instr_o  (bus.instr_D),
        .valid_o  (bus.valid_D)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.pc_F       = pc_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed and random checks of fetch_stage against a model.
//  Revision    : 1.0
// ============================================================================
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] C_PC_RESET = 32'h0000_3000;
    localparam logic [31:0] C_NOP      = 32'h0000_0000;

    logic clk;
    logic reset;
    fetch_stage_if bus ();

    fetch_stage #(
        .PC_RESET  (C_PC_RESET),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: architectural view of IF (fetch address, pending target, F/D slot).
    logic [31:0] m_pc, m_tgt, m_pcD, m_instrD, m_bub;
    logic        m_pend, m_validD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        check("pc_F",       bus.pc_F,            m_pc);
        check("imem_addr",  bus.imem_addr,       m_pc);
        check("pc_D",       bus.pc_D,            m_pcD);
        check("instr_D",    bus.instr_D,         m_instrD);
        check("valid_D",    32'(bus.valid_D),    32'(m_validD));
        check("bubble_cnt", bus.bubble_cnt,      m_bub);
    endtask

    task automatic model_reset();
        m_pc = C_PC_RESET; m_tgt = 32'h0; m_pcD = 32'h0;
        m_instrD = C_NOP; m_validD = 1'b0; m_bub = 32'h0; m_pend = 1'b0;
    endtask

    task automatic step(input logic st, input logic rdy, input logic [2:0] op,
                        input logic cz, input logic [31:0] n, input logic [31:0] rdata);
        logic redir;
        redir = (op == NPC_J) || (op == NPC_JR) || (op == NPC_B && cz);
        assert (!(m_pend && redir && !st))
        else $error("FAIL stimulus redirect while pending observed=1 expected=0");
        bus.stall_D = st; bus.imem_ready = rdy; bus.npc_op = op;
        bus.cmp_zero = cz; bus.npc = n; bus.imem_rdata = rdata;
        @(posedge clk);
        if (!st) begin
            m_pcD = m_pc;
            if (rdy) begin
                m_instrD = rdata; m_validD = 1'b1;
                if (m_pend) begin
                    m_pc = m_tgt; m_pend = 1'b0;
                end else begin
                    m_pc = redir ? n : m_pc + 32'd4;
                end
            end else begin
                m_instrD = C_NOP; m_validD = 1'b0; m_bub = m_bub + 32'd1;
                if (redir) begin
                    m_pend = 1'b1; m_tgt = n;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic        st, rdy, cz;
        logic [2:0]  op;
        bus.stall_D = 1'b0; bus.imem_ready = 1'b0; bus.npc_op = NPC_DEFAULT;
        bus.cmp_zero = 1'b0; bus.npc = 32'h0; bus.imem_rdata = 32'h0;
        reset = 1'b1;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // Sequential fetch, pc_D trailing
        step(0, 1, NPC_DEFAULT, 0, 0, 32'h1111_0001);
        check("seq pc_F 1", bus.pc_F, 32'h3004);
        step(0, 1, NPC_DEFAULT, 0, 0, 32'h1111_0002);
        step(0, 1, NPC_DEFAULT, 0, 0, 32'h1111_0003);
        check("seq pc_F 3", bus.pc_F, 32'h300C);
        check("seq pc_D 3", bus.pc_D, 32'h3008);

        // Taken beq at pc_F=0x3008
        do_reset();
        step(0, 1, NPC_DEFAULT, 0, 0, 32'hAAAA_0000);
        step(0, 1, NPC_DEFAULT, 0, 0, 32'hAAAA_0004);
        step(0, 1, NPC_B, 1, 32'h3040, 32'hAAAA_0008);
        check("beq slot pc_D", bus.pc_D, 32'h3008);
        check("beq target",    bus.pc_F, 32'h3040);

        // Not-taken beq
        step(0, 1, NPC_B, 0, 32'h0, 32'hBBBB_0000);
        check("bne pc_F", bus.pc_F, 32'h3044);

        // jr during IM wait states
        do_reset();
        step(0, 0, NPC_JR, 0, 32'h3100, 32'hDEAD_BEEF);
        step(0, 0, NPC_DEFAULT, 0, 0, 32'hDEAD_BEEF);
        check("jr bubbles", bus.bubble_cnt, 32'd2);
        check("jr pc hold", bus.pc_F, 32'h3000);
        step(0, 1, NPC_DEFAULT, 0, 0, 32'h2400_0001);
        check("jr slot valid", 32'(bus.valid_D), 32'd1);
        check("jr target",     bus.pc_F, 32'h3100);

        // Stall with j in D
        for (int i = 0; i < 3; i++) step(1, 1, NPC_J, 0, 32'h3200, 32'h0800_0C80);
        check("stall pc_F", bus.pc_F, 32'h3100);
        step(0, 1, NPC_J, 0, 32'h3200, 32'h0800_0C80);
        check("j after stall", bus.pc_F, 32'h3200);

        // Unaligned target and PC wrap
        step(0, 1, NPC_J, 0, 32'hFFFF_FFFE, 32'h5);
        step(0, 1, NPC_DEFAULT, 0, 0, 32'h6);
        check("pc wrap", bus.pc_F, 32'h0000_0002);

        // Reset mid-run at pc_F=0x3010 with bubbles counted
        do_reset();
        step(0, 0, NPC_DEFAULT, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, NPC_DEFAULT, 0, 0, 32'h100 + 32'(i));
        check("pre-reset pc_F", bus.pc_F, 32'h3010);
        #2;
        do_reset();
        check("async reset pc_F", bus.pc_F, 32'h3000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(99, 0) < 20);
            rdy = ($urandom_range(99, 0) < 65);
            op  = 3'($urandom_range(3, 0));
            cz  = 1'($urandom);
            if (m_pend) op = NPC_DEFAULT;
            step(st, rdy, op, cz, $urandom, $urandom);
            if (i == 250) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
